vm1_irq_responder: RTL and testbench

//  Interrupt-acknowledge responder, on the far side of the processor's virq/istb/ivec/iack interface.

---
 rtl/vm1_irq_pkg.sv | 18 +
 rtl/vm1_irq_if.sv | 12 +
 rtl/vm1_irq_prio_enc.sv | 26 ++
 rtl/vm1_irq_responder.sv | 129 ++++++++++++
 tb/tb_vm1_irq_responder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vm1_irq_pkg.sv
// Shared constants and state encoding for the vm1 interrupt-acknowledge responder.
package vm1_irq_pkg;

    localparam int unsigned VEC_W        = 16;
    localparam int unsigned HOLDOFF      = 2;
    localparam logic [15:0] VEC_SPUR_DEF = 16'o0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StGrant = ST_GRANT,
        StHold  = ST_HOLD
    } irq_state_e;

endpackage

// File: rtl/vm1_irq_if.sv
// Processor-side vectored interrupt handshake: virq/istb/ivec/iack.
interface vm1_irq_if;

    logic                          virq;
    logic                          istb;
    logic                          iack;
    logic [vm1_irq_pkg::VEC_W-1:0] ivec;

    modport master (input virq, input iack, input ivec, output istb);
    modport slave  (output virq, output iack, output ivec, input istb);

endinterface

// File: rtl/vm1_irq_prio_enc.sv
// Combinational priority encoder: first set request at or after start, wrapping modulo NSRC.
module vm1_irq_prio_enc #(
    parameter int unsigned NSRC = 8,
    parameter int unsigned SELW = 3
) (
    input  logic [NSRC-1:0] req,
    input  logic [SELW-1:0] start,
    output logic            found,
    output logic [SELW-1:0] idx
);

    // Walk from the far end so the candidate nearest to start is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = int'(NSRC) - 1; k >= 0; k--) begin
            int j;
            j = (int'(start) + k) % int'(NSRC);
            if (req[j]) begin
                found = 1'b1;
                idx   = SELW'(j);
            end
        end
    end

endmodule

// File: rtl/vm1_irq_responder.sv
// Interrupt-acknowledge responder: collects requests, asserts virq, answers istb with a vector.
// Define IRQ_RR_EN for round-robin arbitration; default build uses fixed priority (index 0 first).
module vm1_irq_responder
    import vm1_irq_pkg::*;
#(
    parameter int unsigned NSRC     = 8,
    parameter logic [15:0] VEC_SPUR = VEC_SPUR_DEF
) (
    input  logic                  clk_p,
    input  logic                  rst,
    input  logic [NSRC-1:0]       irq_req,
    input  logic [VEC_W*NSRC-1:0] vec_tbl,
    output logic [NSRC-1:0]       irq_take,
    vm1_irq_if.slave              bus
);

    localparam int unsigned SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

    irq_state_e        state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic              spur_q, spur_d;
    logic [VEC_W-1:0]  ivec_q, ivec_d;
    logic              iack_q, iack_d;
    logic              virq_q, virq_d;
    logic [NSRC-1:0]   take_q, take_d;
    logic [1:0]        holdoff_q, holdoff_d;
    logic [SELW-1:0]   start;
    logic              enc_found;
    logic [SELW-1:0]   enc_idx;
    logic [VEC_W-1:0]  sel_vec;

`ifdef IRQ_RR_EN
    logic [SELW-1:0]   rr_q, rr_d;
    assign start = (int'(rr_q) == int'(NSRC) - 1) ? '0 : rr_q + 1'b1;
`else
    assign start = '0;
`endif

    vm1_irq_prio_enc #(
        .NSRC (NSRC),
        .SELW (SELW)
    ) u_prio_enc (
        .req   (irq_req),
        .start (start),
        .found (enc_found),
        .idx   (enc_idx)
    );

    assign sel_vec = vec_tbl[int'(sel_q) * VEC_W +: VEC_W];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        spur_d    = spur_q;
        ivec_d    = ivec_q;
        iack_d    = iack_q;
        take_d    = '0;
        holdoff_d = holdoff_q;
`ifdef IRQ_RR_EN
        rr_d      = rr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (holdoff_q != 2'd0) holdoff_d = holdoff_q - 2'd1;
                if (bus.istb) begin
                    state_d = StGrant;
                    sel_d   = enc_idx;
                    spur_d  = ~enc_found;
                end
            end
            StGrant: begin
                state_d = StHold;
                iack_d  = 1'b1;
                ivec_d  = spur_q ? VEC_SPUR : {sel_vec[VEC_W-1:2], 2'b00};
                if (!spur_q) begin
                    take_d[sel_q] = 1'b1;
`ifdef IRQ_RR_EN
                    rr_d = sel_q;
`endif
                end
            end
            StHold: begin
                if (!bus.istb) begin
                    state_d   = StIdle;
                    iack_d    = 1'b0;
                    ivec_d    = '0;
                    holdoff_d = 2'(HOLDOFF);
                end
            end
            default: state_d = StIdle;
        endcase
        // Suppressed until the granted device has had time to drop its request.
        virq_d = (state_d == StIdle) && (holdoff_d == 2'd0) && (|irq_req);
    end

    always_ff @(posedge clk_p) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            spur_q    <= 1'b0;
            ivec_q    <= '0;
            iack_q    <= 1'b0;
            virq_q    <= 1'b0;
            take_q    <= '0;
            holdoff_q <= '0;
`ifdef IRQ_RR_EN
            rr_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            spur_q    <= spur_d;
            ivec_q    <= ivec_d;
            iack_q    <= iack_d;
            virq_q    <= virq_d;
            take_q    <= take_d;
            holdoff_q <= holdoff_d;
`ifdef IRQ_RR_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign irq_take = take_q;
    assign bus.virq = virq_q;
    assign bus.iack = iack_q;
    assign bus.ivec = ivec_q;

endmodule

// File: tb/tb_vm1_irq_responder.sv
// Directed, table-driven bench for vm1_irq_responder (fixed priority, or round-robin with IRQ_RR_EN).
module tb_vm1_irq_responder;

    localparam int unsigned NSRC = 8;

    logic              clk_p = 1'b0;
    logic              rst   = 1'b1;
    logic [NSRC-1:0]   irq_req = '0;
    logic [16*NSRC-1:0] vec_tbl;
    logic [NSRC-1:0]   irq_take;

    vm1_irq_if bus ();

    vm1_irq_responder #(
        .NSRC     (NSRC),
        .VEC_SPUR (16'o0)
    ) dut (
        .clk_p    (clk_p),
        .rst      (rst),
        .irq_req  (irq_req),
        .vec_tbl  (vec_tbl),
        .irq_take (irq_take),
        .bus      (bus)
    );

    always #5 clk_p = ~clk_p;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  req_add;
        logic [15:0] vec;
        logic [7:0]  take;
    } row_t;

    row_t tbl[5];

    function automatic logic [15:0] exp_vec(input int i);
        return 16'(16'o040 + 8 * i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.istb = 1'b0;
        @(negedge clk_p);
        @(negedge clk_p);
        rst = 1'b0;
    endtask

    // Full handshake; bench acts as the peripheral and drops any taken request.
    task automatic hs(output logic [15:0] v, output logic [7:0] t);
        int n;
        t = '0;
        n = 0;
        bus.istb = 1'b1;
        do begin
            @(negedge clk_p);
            n++;
            t |= irq_take;
        end while (!bus.iack && n < 10);
        chk("hs_latency", n, 2);
        v = bus.ivec;
        irq_req &= ~t;
        @(negedge clk_p);
        chk("take_one_cycle", irq_take, 0);
        chk("iack_held", bus.iack, 1);
        chk("ivec_stable", bus.ivec, v);
        chk("virq_in_hold", bus.virq, 0);
        bus.istb = 1'b0;
        @(negedge clk_p);
        chk("iack_release", bus.iack, 0);
        chk("ivec_release", bus.ivec, 0);
        chk("virq_exit", bus.virq, 0);
        @(negedge clk_p);
        chk("virq_holdoff", bus.virq, 0);
        @(negedge clk_p);
        chk("virq_resume", bus.virq, 32'(|irq_req));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [7:0]  t;
        int          npulse;

        for (int i = 0; i < int'(NSRC); i++)
            vec_tbl[16*i +: 16] = exp_vec(i) | 16'(i % 4);

        tbl[0] = '{8'h04,        16'o060, 8'h04};
`ifdef IRQ_RR_EN
        tbl[1] = '{8'b1001_0010, exp_vec(4), 8'h10};
        tbl[2] = '{8'h00,        exp_vec(7), 8'h80};
        tbl[3] = '{8'h00,        exp_vec(1), 8'h02};
`else
        tbl[1] = '{8'b1001_0010, exp_vec(1), 8'h02};
        tbl[2] = '{8'h00,        exp_vec(4), 8'h10};
        tbl[3] = '{8'h00,        exp_vec(7), 8'h80};
`endif
        tbl[4] = '{8'h00,        16'o0,   8'h00};

        bus.istb = 1'b0;
        irq_req  = 8'hFF;
        @(negedge clk_p);
        @(negedge clk_p);
        chk("rst_virq", bus.virq, 0);
        chk("rst_iack", bus.iack, 0);
        chk("rst_ivec", bus.ivec, 0);
        chk("rst_take", irq_take, 0);
        irq_req = '0;
        rst = 1'b0;
        @(negedge clk_p);

        // Single source, fixed/rr priority order, then spurious with nothing pending.
        for (int r = 0; r < 5; r++) begin
            irq_req |= tbl[r].req_add;
            if (r == 0) chk("virq_latency", bus.virq, 0);
            @(negedge clk_p);
            chk($sformatf("row%0d_virq", r), bus.virq, 32'(|irq_req));
            hs(v, t);
            chk($sformatf("row%0d_vec", r), v, tbl[r].vec);
            chk($sformatf("row%0d_take", r), t, tbl[r].take);
        end

        // Request withdrawn between virq and istb.
        irq_req = 8'h01;
        @(negedge clk_p);
        chk("withdraw_virq", bus.virq, 1);
        irq_req = '0;
        hs(v, t);
        chk("spur_vec", v, 16'o0);
        chk("spur_take", t, 0);

        // istb held high 20 cycles: one grant only.
        do_reset();
        irq_req = 8'h09;
        @(negedge clk_p);
        bus.istb = 1'b1;
        npulse = 0;
        t = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_p);
            if (irq_take != '0) npulse++;
            t |= irq_take;
            irq_req &= ~irq_take;
        end
        chk("long_istb_pulses", npulse, 1);
`ifdef IRQ_RR_EN
        chk("long_istb_take", t, 8'h08);
`else
        chk("long_istb_take", t, 8'h01);
`endif
        chk("long_istb_iack", bus.iack, 1);
        chk("long_istb_virq", bus.virq, 0);
        bus.istb = 1'b0;
        repeat (3) @(negedge clk_p);
        hs(v, t);
`ifdef IRQ_RR_EN
        chk("second_grant_take", t, 8'h01);
        chk("second_grant_vec", v, exp_vec(0));
`else
        chk("second_grant_take", t, 8'h08);
        chk("second_grant_vec", v, exp_vec(3));
`endif

        // Reset in the middle of HOLD.
        do_reset();
        irq_req = 8'h01;
        @(negedge clk_p);
        bus.istb = 1'b1;
        npulse = 0;
        do begin
            @(negedge clk_p);
            npulse++;
        end while (!bus.iack && npulse < 10);
        chk("midrst_got_iack", bus.iack, 1);
        @(negedge clk_p);
        rst = 1'b1;
        bus.istb = 1'b0;
        @(negedge clk_p);
        chk("midrst_iack", bus.iack, 0);
        chk("midrst_ivec", bus.ivec, 0);
        chk("midrst_virq", bus.virq, 0);
        chk("midrst_take", irq_take, 0);
        rst = 1'b0;
        @(negedge clk_p);
        chk("midrst_virq_resume", bus.virq, 1);
        irq_req = '0;

        // All sources pending, eight handshakes.
        do_reset();
        irq_req = 8'hFF;
        @(negedge clk_p);
        for (int i = 0; i < 8; i++) begin
            int e;
`ifdef IRQ_RR_EN
            e = (i + 1) % 8;
`else
            e = i;
`endif
            hs(v, t);
            chk($sformatf("all_take%0d", i), t, 32'(8'h01 << e));
            chk($sformatf("all_vec%0d", i), v, exp_vec(e));
`ifdef IRQ_RR_EN
            irq_req = 8'hFF;
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
